// File: rtl/time_of_day_counter.sv
// Time-of-day counter: prescaler, sec/min/hour chain, range-checked set handshake, 12/24h view.
// Optional alarm compare enabled by defining TOD_ALARM_EN.
module time_of_day_counter #(
   parameter int CLK_DIV       = 1,
   parameter int HOURS_PER_DAY = 24
) (
   input  logic       clk_1Hz,
   input  logic       rst,
   input  logic       en,
   input  logic       set_valid,
   output logic       set_ready,
   input  logic [5:0] set_sec,
   input  logic [5:0] set_min,
   input  logic [4:0] set_hr,
   output logic       set_err,
   input  logic       mode_12h,
   output logic [5:0] seconds,
   output logic [5:0] minutes,
   output logic [4:0] hours,
   output logic [4:0] disp_hours,
   output logic       pm,
   output logic       sec_tick,
   output logic       min_tick,
   output logic       hour_tick,
`ifdef TOD_ALARM_EN
   input  logic       alarm_set,
   input  logic [5:0] alarm_min,
   input  logic [4:0] alarm_hr,
   output logic       alarm,
`endif
   output logic       day_tick
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1 || CLK_DIV > 65535) begin : g_bad_div
      $error("time_of_day_counter: CLK_DIV out of range 1..65535");
   end
   if (HOURS_PER_DAY < 2 || HOURS_PER_DAY > 32) begin : g_bad_hpd
      $error("time_of_day_counter: HOURS_PER_DAY out of range 2..32");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    sec_q, sec_d, min_q, min_d;
   logic [4:0]    hr_q, hr_d;
   logic          ready_q, ready_d, err_q, err_d;
   logic          stick_q, stick_d, mtick_q, mtick_d, htick_q, htick_d, dtick_q, dtick_d;

   logic          presc_wrap, sec_stb, xfer, set_ok;
   logic          sec_wrap, min_wrap, hr_wrap;
   logic [5:0]    sec_nx, min_nx;
   logic [4:0]    hr_nx, h_mod;

   assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));
   assign sec_stb    = en & presc_wrap;
   assign xfer       = set_valid & ready_q;
   assign set_ok     = (set_sec <= 6'd59) && (set_min <= 6'd59) &&
                       ({1'b0, set_hr} < 6'(HOURS_PER_DAY));

   assign sec_wrap = (sec_q == 6'd59);
   assign min_wrap = (min_q == 6'd59);
   assign hr_wrap  = (hr_q == 5'(HOURS_PER_DAY - 1));
   assign sec_nx   = sec_wrap ? 6'd0 : sec_q + 6'd1;
   assign min_nx   = sec_wrap ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
   assign hr_nx    = (sec_wrap && min_wrap) ? (hr_wrap ? 5'd0 : hr_q + 5'd1) : hr_q;

   always_comb begin
      presc_d = presc_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      ready_d = 1'b1;
      err_d   = 1'b0;
      stick_d = 1'b0;
      mtick_d = 1'b0;
      htick_d = 1'b0;
      dtick_d = 1'b0;
      if (en) presc_d = presc_wrap ? '0 : presc_q + 1'b1;
      // A transfer owns this edge; a coincident second strobe is dropped, not deferred.
      if (xfer) begin
         ready_d = 1'b0;
         if (set_ok) begin
            sec_d   = set_sec;
            min_d   = set_min;
            hr_d    = set_hr;
            presc_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end else if (sec_stb) begin
         sec_d   = sec_nx;
         min_d   = min_nx;
         hr_d    = hr_nx;
         stick_d = 1'b1;
         mtick_d = sec_wrap;
         htick_d = sec_wrap & min_wrap;
         dtick_d = sec_wrap & min_wrap & hr_wrap;
      end
   end

   always_ff @(posedge clk_1Hz or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         ready_q <= 1'b1;
         err_q   <= 1'b0;
         stick_q <= 1'b0;
         mtick_q <= 1'b0;
         htick_q <= 1'b0;
         dtick_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         stick_q <= stick_d;
         mtick_q <= mtick_d;
         htick_q <= htick_d;
         dtick_q <= dtick_d;
      end
   end

   always_comb begin
      h_mod = hr_q;
      if (hr_q >= 5'd24)      h_mod = hr_q - 5'd24;
      else if (hr_q >= 5'd12) h_mod = hr_q - 5'd12;
   end

   assign disp_hours = mode_12h ? ((h_mod == 5'd0) ? 5'd12 : h_mod) : hr_q;
   assign pm         = mode_12h & (hr_q >= 5'd12);
   assign seconds    = sec_q;
   assign minutes    = min_q;
   assign hours      = hr_q;
   assign set_ready  = ready_q;
   assign set_err    = err_q;
   assign sec_tick   = stick_q;
   assign min_tick   = mtick_q;
   assign hour_tick  = htick_q;
   assign day_tick   = dtick_q;

`ifdef TOD_ALARM_EN
   logic       armed_q, alarm_q;
   logic [5:0] al_min_q;
   logic [4:0] al_hr_q;

   // Only a counted minute rollover can fire; loads go through the xfer branch instead.
   always_ff @(posedge clk_1Hz or posedge rst) begin
      if (rst) begin
         armed_q  <= 1'b0;
         alarm_q  <= 1'b0;
         al_min_q <= '0;
         al_hr_q  <= '0;
      end else begin
         alarm_q <= sec_stb & ~xfer & sec_wrap & armed_q &
                    (min_nx == al_min_q) & (hr_nx == al_hr_q);
         if (alarm_set) begin
            armed_q  <= 1'b1;
            al_min_q <= alarm_min;
            al_hr_q  <= alarm_hr;
         end
      end
   end

   assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: one DUT at CLK_DIV=1 and one at CLK_DIV=4.
module tb_time_of_day_counter;

   logic       clk = 1'b0;
   logic       rst, en, set_valid, mode_12h;
   logic [5:0] set_sec, set_min;
   logic [4:0] set_hr;
   logic       set_ready, set_err, pm, sec_tick, min_tick, hour_tick, day_tick;
   logic [5:0] seconds, minutes;
   logic [4:0] hours, disp_hours;

   logic       rst4, en4, sv4;
   logic       set_ready4, set_err4, pm4, sec_tick4, min_tick4, hour_tick4, day_tick4;
   logic [5:0] seconds4, minutes4;
   logic [4:0] hours4, disp_hours4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   time_of_day_counter #(.CLK_DIV(1), .HOURS_PER_DAY(24)) u1 (
      .clk_1Hz(clk), .rst(rst), .en(en), .set_valid(set_valid), .set_ready(set_ready),
      .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr), .set_err(set_err),
      .mode_12h(mode_12h), .seconds(seconds), .minutes(minutes), .hours(hours),
      .disp_hours(disp_hours), .pm(pm), .sec_tick(sec_tick), .min_tick(min_tick),
      .hour_tick(hour_tick), .day_tick(day_tick));

   time_of_day_counter #(.CLK_DIV(4), .HOURS_PER_DAY(24)) u4 (
      .clk_1Hz(clk), .rst(rst4), .en(en4), .set_valid(sv4), .set_ready(set_ready4),
      .set_sec(set_sec), .set_min(set_min), .set_hr(set_hr), .set_err(set_err4),
      .mode_12h(mode_12h), .seconds(seconds4), .minutes(minutes4), .hours(hours4),
      .disp_hours(disp_hours4), .pm(pm4), .sec_tick(sec_tick4), .min_tick(min_tick4),
      .hour_tick(hour_tick4), .day_tick(day_tick4));

   // Load request presented one edge later, transferred on the edge after; returns #1 past transfer.
   task automatic do_load(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
      @(posedge clk); #1;
      set_valid = 1'b1; set_sec = s; set_min = m; set_hr = h;
      @(posedge clk); #1;
      set_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; set_valid = 1'b0; mode_12h = 1'b0;
      set_sec = '0; set_min = '0; set_hr = '0;
      rst4 = 1'b1; en4 = 1'b1; sv4 = 1'b0;
      #2;
      n_checks++;
      if ({hours, minutes, seconds} !== 17'd0) begin
         n_errors++; $display("FAIL reset_time got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds);
      end
      n_checks++;
      if ({set_ready, set_err} !== 2'b10) begin
         n_errors++; $display("FAIL reset_hs got ready=%b err=%b exp ready=1 err=0", set_ready, set_err);
      end
      n_checks++;
      if ({sec_tick, min_tick, hour_tick, day_tick} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_ticks got %b exp 0000", {sec_tick, min_tick, hour_tick, day_tick});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_count;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (seconds !== 6'(i % 60)) begin
            n_errors++; $display("FAIL count_sec i=%0d got %0d exp %0d", i, seconds, i % 60);
         end
         n_checks++;
         if (min_tick !== (i == 60)) begin
            n_errors++; $display("FAIL count_min_tick i=%0d got %b exp %b", i, min_tick, (i == 60));
         end
      end
      n_checks++;
      if ({hours, minutes} !== {5'd0, 6'd1}) begin
         n_errors++; $display("FAIL count_min got %0d:%0d exp 0:1", hours, minutes);
      end
   endtask

   task automatic test_day_wrap;
      do_load(6'd58, 6'd59, 5'd23);
      n_checks++;
      if ({hours, minutes, seconds, set_ready, sec_tick} !== {5'd23, 6'd59, 6'd58, 1'b0, 1'b0}) begin
         n_errors++; $display("FAIL wrap_load got %0d:%0d:%0d ready=%b stick=%b exp 23:59:58 ready=0 stick=0",
                              hours, minutes, seconds, set_ready, sec_tick);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd23, 6'd59, 6'd59} ||
          {sec_tick, min_tick, hour_tick, day_tick} !== 4'b1000) begin
         n_errors++; $display("FAIL wrap_59 got %0d:%0d:%0d ticks=%b exp 23:59:59 ticks=1000",
                              hours, minutes, seconds, {sec_tick, min_tick, hour_tick, day_tick});
      end
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== 17'd0 ||
          {sec_tick, min_tick, hour_tick, day_tick} !== 4'b1111) begin
         n_errors++; $display("FAIL wrap_00 got %0d:%0d:%0d ticks=%b exp 0:0:0 ticks=1111",
                              hours, minutes, seconds, {sec_tick, min_tick, hour_tick, day_tick});
      end
      @(posedge clk); #1;
      n_checks++;
      if (seconds !== 6'd1 || {sec_tick, min_tick, hour_tick, day_tick} !== 4'b1000) begin
         n_errors++; $display("FAIL wrap_after got sec=%0d ticks=%b exp sec=1 ticks=1000",
                              seconds, {sec_tick, min_tick, hour_tick, day_tick});
      end
   endtask

   task automatic test_set_handshake;
      @(posedge clk); #1;
      set_valid = 1'b1; set_sec = 6'd56; set_min = 6'd34; set_hr = 5'd12;
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd56} || set_ready !== 1'b0 ||
          sec_tick !== 1'b0 || set_err !== 1'b0) begin
         n_errors++; $display("FAIL set_ok got %0d:%0d:%0d ready=%b stick=%b err=%b exp 12:34:56 0 0 0",
                              hours, minutes, seconds, set_ready, sec_tick, set_err);
      end
      // set_valid still high: must not be re-accepted while set_ready is low
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd57} || set_ready !== 1'b1 || sec_tick !== 1'b1) begin
         n_errors++; $display("FAIL set_hold got %0d:%0d:%0d ready=%b stick=%b exp 12:34:57 1 1",
                              hours, minutes, seconds, set_ready, sec_tick);
      end
      set_sec = 6'd0; set_min = 6'd60; set_hr = 5'd1;
      @(posedge clk); #1;
      set_valid = 1'b0;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd57} || set_err !== 1'b1 ||
          set_ready !== 1'b0 || sec_tick !== 1'b0) begin
         n_errors++; $display("FAIL set_bad_min got %0d:%0d:%0d err=%b ready=%b stick=%b exp 12:34:57 1 0 0",
                              hours, minutes, seconds, set_err, set_ready, sec_tick);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd58} || set_err !== 1'b0 || set_ready !== 1'b1) begin
         n_errors++; $display("FAIL set_err_pulse got %0d:%0d:%0d err=%b ready=%b exp 12:34:58 0 1",
                              hours, minutes, seconds, set_err, set_ready);
      end
      set_valid = 1'b1; set_min = 6'd0; set_hr = 5'd24;
      @(posedge clk); #1;
      set_valid = 1'b0;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd58} || set_err !== 1'b1) begin
         n_errors++; $display("FAIL set_bad_hr got %0d:%0d:%0d err=%b exp 12:34:58 1",
                              hours, minutes, seconds, set_err);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd12, 6'd34, 6'd59} || set_err !== 1'b0) begin
         n_errors++; $display("FAIL set_bad_hr_after got %0d:%0d:%0d err=%b exp 12:34:59 0",
                              hours, minutes, seconds, set_err);
      end
   endtask

   task automatic test_12h;
      mode_12h = 1'b1;
      do_load(6'd0, 6'd0, 5'd0);
      n_checks++;
      if ({disp_hours, pm} !== {5'd12, 1'b0}) begin
         n_errors++; $display("FAIL h12_midnight got disp=%0d pm=%b exp 12 0", disp_hours, pm);
      end
      do_load(6'd0, 6'd0, 5'd12);
      n_checks++;
      if ({hours, disp_hours, pm} !== {5'd12, 5'd12, 1'b1}) begin
         n_errors++; $display("FAIL h12_noon got hr=%0d disp=%0d pm=%b exp 12 12 1", hours, disp_hours, pm);
      end
      do_load(6'd0, 6'd0, 5'd13);
      n_checks++;
      if ({disp_hours, pm} !== {5'd1, 1'b1}) begin
         n_errors++; $display("FAIL h12_13 got disp=%0d pm=%b exp 1 1", disp_hours, pm);
      end
      mode_12h = 1'b0;
      #1;
      n_checks++;
      if ({disp_hours, pm} !== {5'd13, 1'b0}) begin
         n_errors++; $display("FAIL h24_13 got disp=%0d pm=%b exp 13 0", disp_hours, pm);
      end
   endtask

   task automatic test_async_reset;
      do_load(6'd19, 6'd10, 5'd5);
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds, sec_tick} !== {5'd5, 6'd10, 6'd20, 1'b1}) begin
         n_errors++; $display("FAIL ar_pre got %0d:%0d:%0d stick=%b exp 5:10:20 1",
                              hours, minutes, seconds, sec_tick);
      end
      #1;
      set_valid = 1'b1; set_sec = 6'd7; set_min = 6'd7; set_hr = 5'd7;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({hours, minutes, seconds, disp_hours, pm} !== 23'd0 ||
          {sec_tick, min_tick, hour_tick, day_tick, set_err, set_ready} !== 6'b000001) begin
         n_errors++; $display("FAIL ar_immediate got %0d:%0d:%0d disp=%0d pm=%b ticks=%b err=%b ready=%b",
                              hours, minutes, seconds, disp_hours, pm,
                              {sec_tick, min_tick, hour_tick, day_tick}, set_err, set_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== 17'd0) begin
         n_errors++; $display("FAIL ar_held got %0d:%0d:%0d exp 0:0:0", hours, minutes, seconds);
      end
      set_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({hours, minutes, seconds} !== {5'd0, 6'd0, 6'd1}) begin
         n_errors++; $display("FAIL ar_release got %0d:%0d:%0d exp 0:0:1", hours, minutes, seconds);
      end
   endtask

   task automatic test_prescaler;
      logic       tick_exp;
      logic [5:0] sec_exp;
      rst4 = 1'b0; en4 = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk); #1;
         tick_exp = (i == 4) || (i == 8) || (i == 15);
         sec_exp  = (i < 4) ? 6'd0 : (i < 8) ? 6'd1 : (i < 15) ? 6'd2 : 6'd3;
         n_checks++;
         if (sec_tick4 !== tick_exp || seconds4 !== sec_exp) begin
            n_errors++; $display("FAIL presc i=%0d got tick=%b sec=%0d exp tick=%b sec=%0d",
                                 i, sec_tick4, seconds4, tick_exp, sec_exp);
         end
         if (i == 10) en4 = 1'b0;
         if (i == 13) en4 = 1'b1;
      end
   endtask

   initial begin
      test_reset;
      test_count;
      test_day_wrap;
      test_set_handshake;
      test_12h;
      test_async_reset;
      test_prescaler;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
